hex_scan_disp: RTL
==================

Name: hex_scan_disp

Overview:
Parametrised multiplexed driver for a DIGITS-wide common-anode 7-segment display, the successor to the single-digit combinational hex decoder.
- Accepts a packed hex word plus decimal-point and blank masks through a load strobe.
- Double-buffers the loaded values so a new value only takes effect at a frame boundary (no tearing).
- Scans one digit per PRESCALE clocks and drives registered segment, decimal-point and anode lines.
- Sits between the register/debug logic and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..16)
PRESCALE, 50000, clocks per digit slot (>=2)
SEG_ACTIVE_LOW, 1, 1: seg_o/dp_o driven low = lit
AN_ACTIVE_LOW, 1, 1: an_o driven low = digit enabled

Ports:
clk_i  in  1  system clock; single clock domain
rst_i  in  1  synchronous active-high reset
data_i  in  4*DIGITS  packed nibbles; digit 0 = data_i[3:0] (rightmost)
dp_i  in  DIGITS  decimal-point enable per digit, active-high
blank_i  in  DIGITS  force digit dark, active-high
lz_en_i  in  1  leading-zero suppression enable
load_i  in  1  capture data_i/dp_i/blank_i/lz_en_i into pending buffer
seg_o  out  7  segments {g,f,e,d,c,b,a}, bit0 = a
dp_o  out  1  decimal point
an_o  out  DIGITS  anode enables, one-hot (or all inactive)
frame_o  out  1  one-cycle pulse at end of each full scan (commit point)

Behaviour:
- Reset, applied on the clock edge with rst_i=1:
  - Clears the prescaler, digit index, pending buffer, display buffer and pending flag.
  - Outputs: seg_o all unlit (7'h7F when active-low), dp_o unlit, an_o all inactive, frame_o=0.
  - Reset mid-scan aborts the scan immediately; it overrides load_i.
- Prescaler: cnt counts 0..PRESCALE-1 and wraps. tick = (cnt==PRESCALE-1).
- Digit index: idx advances on each tick, DIGITS-1 wraps to 0.
- Frame boundary: tick with idx==DIGITS-1. On this edge:
  - frame_o=1 for exactly one cycle.
  - If pending is set, pending is copied to the display buffer and pending is cleared.
- load_i=1 on any non-boundary cycle: inputs are captured into the pending buffer and pending is set. A later load before the boundary overwrites the earlier one; last load wins.
- load_i=1 on the boundary cycle: the inputs are written straight into the display buffer. pending is cleared. The new frame uses them.
- Output pipeline:
  - seg_o, dp_o and an_o are registered, computed from the current idx and the display buffer.
  - Latency is one cycle after an idx change, so digit k is visible for exactly PRESCALE cycles.
- Per-digit visibility. Digit i is dark when any of these holds:
  - blank_i[i] is set.
  - lz_en is set, i>0, and nibbles DIGITS-1..i are all zero.
  - Digit 0 is never suppressed by leading-zero suppression.
- Dark digit: an_o is all inactive, seg_o is unlit and dp_o is unlit. Otherwise only an_o[idx] is active.
- dp_o lights only when the digit is visible and dp[idx]=1.
- Glyphs, active-high internal a..g: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Polarity: when SEG_ACTIVE_LOW=1 the output is inverted (for example 0 -> 7'b1000000). an_o is inverted the same way when AN_ACTIVE_LOW=1.
- DIGITS=1: idx is held at 0 and every tick is a frame boundary.

Decomposition:
- Shared package hex_pkg holds:
  - The 16-entry glyph constant table.
  - SEG_OFF.
  - The segment bit-order constants.
- Sub-module hex_seg_dec (combinational nibble -> active-high segments, drawn from hex_pkg). It is reused by later display blocks.
- Top level contains the prescaler, idx counter, buffers, leading-zero logic and output registers.

Test Plan:
- Bench setting: DIGITS=4, PRESCALE=4, both polarities active-low.
- Reset: hold rst_i 3 cycles, and again mid-scan at idx=2 -> next cycle seg_o=7'h7F, dp_o=1, an_o=4'hF, frame_o=0. After release, digit 0 shows "0" (seg_o=7'b1000000, an_o=4'b1110).
- Basic scan: load 16'h12AF, wait one frame_o. Following slots must show:
  - F: seg_o 7'b0001110, an_o 4'b1110
  - A: seg_o 7'b0001000, an_o 4'b1101
  - 2: seg_o 7'b0100100, an_o 4'b1011
  - 1: seg_o 7'b1111001, an_o 4'b0111
  - Each slot lasts 4 cycles; frame_o pulses every 16 cycles.
- Leading zeros: lz_en=1 with data 16'h0050 -> digits 3 and 2 dark (an_o 4'hF, seg_o 7'h7F); digit 1 seg_o 7'b0010010; digit 0 seg_o 7'b1000000. With data 16'h0000, only digit 0 is lit.
- Tear-free load:
  - Load 16'h1111, then 16'h2222 at idx=1 of the same frame -> current frame unchanged; next frame shows 2222 on all digits; 1111 never appears.
  - A load coincident with frame_o takes effect in the immediately following frame.
- Masks: dp_i=4'b0100, blank_i=4'b0001, data 16'h8888 -> digit 2 dp_o=0; digit 0 an_o 4'hF with seg_o 7'h7F; other digits dp_o=1.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared 7-segment definitions: glyph table, segment bit order, dark pattern.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package hex_pkg;

    localparam int SEG_W = 7;

    // Segment bit positions inside a {g,f,e,d,c,b,a} vector.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // All segments dark, active-high internal form.
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // Active-high glyphs, entry n is the pattern for nibble n (0..9, A, b, C, d, E, F).
    localparam logic [15:0][SEG_W-1:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] glyph(input logic [3:0] nib);
        return GLYPHS[nib];
    endfunction

endpackage

// File: rtl/hex_seg_dec.sv
// Nibble to active-high 7-segment decoder ({g,f,e,d,c,b,a}, bit0 = a).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
// Ports: nib_i - hex digit in; seg_o - active-high segment pattern out.
module hex_seg_dec
    import hex_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = glyph(nib_i);
    end

endmodule

// File: rtl/hex_scan_disp.sv
// Multiplexed DIGITS-wide 7-segment scanner with frame-aligned double buffering.
// Latency: outputs registered, one cycle behind the digit index; loads commit at frame end.
// Backpressure: none; load_i is always accepted (last load before a frame boundary wins).
// Ports: clk_i/rst_i (sync, active-high); data_i/dp_i/blank_i/lz_en_i captured on load_i;
//        seg_o/dp_o/an_o drive the display pins; frame_o pulses once per full scan.
module hex_scan_disp
    import hex_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic                  lz_en_i,
    input  logic                  load_i,
    output logic [SEG_W-1:0]      seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
        logic                lz;
    } disp_buf_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    disp_buf_t        pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    disp_buf_t        disp_q, disp_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic             frame_q, frame_d;

    logic             tick;
    logic             boundary;
    disp_buf_t        in_buf;

    logic [DIGITS-1:0] lz_mask;
    logic             all_zero;
    logic [DIGITS-1:0] an_sel;
    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic             cur_dark;
    logic [SEG_W-1:0] glyph_seg;

    // Prescaler, digit index and frame boundary.
    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        boundary = tick && (idx_q == IDX_LAST);
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        frame_d = boundary;
    end

    // Double buffer: loads land in pending and only reach the display buffer at a
    // frame boundary; a load on the boundary cycle itself bypasses pending so the
    // frame that starts right now already uses it.
    always_comb begin
        in_buf     = '{data: data_i, dp: dp_i, blank: blank_i, lz: lz_en_i};
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        if (boundary) begin
            pend_vld_d = 1'b0;
            if (load_i) begin
                disp_d = in_buf;
            end else if (pend_vld_q) begin
                disp_d = pend_q;
            end
        end else if (load_i) begin
            pend_d     = in_buf;
            pend_vld_d = 1'b1;
        end
    end

    // lz_mask[i] is set when nibbles DIGITS-1..i are all zero; digit 0 is excluded
    // so an all-zero word still shows a single "0".
    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero && (disp_q.data[4*i +: 4] == 4'h0);
            lz_mask[i] = all_zero && (i > 0);
        end
    end

    // Select the digit addressed by idx (compare-based so non-power-of-two DIGITS
    // and DIGITS=1 need no special indexing).
    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        an_sel   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_q.data[4*i +: 4];
                cur_dp    = disp_q.dp[i];
                cur_dark  = disp_q.blank[i] || (disp_q.lz && lz_mask[i]);
                an_sel[i] = 1'b1;
            end
        end
    end

    hex_seg_dec u_seg_dec (
        .nib_i (cur_nib),
        .seg_o (glyph_seg)
    );

    always_comb begin
        seg_d = cur_dark ? SEG_OFF : glyph_seg;
        dp_d  = !cur_dark && cur_dp;
        an_d  = cur_dark ? '0 : an_sel;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            disp_q     <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b0;
            an_q       <= '0;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    // Registers hold active-high values; pin polarity is a static inversion.
    assign seg_o   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp_o    = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
    assign an_o    = AN_ACTIVE_LOW ? ~an_q : an_q;
    assign frame_o = frame_q;

endmodule
